// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: hex glyph table, blank codes, scan FSM states.
// Segment codes are active-low, bit order gfedcba.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [0:0] GUARD_S = 1'b0;
  localparam logic [0:0] DRIVE_S = 1'b1;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_SEG[n];
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Control and display bundle between the adder datapath and the scanner.
// The master side drives the value/strobes; the scanner owns the display pins.
interface hex_display_scanner_if;

  logic [31:0] value;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_done;

  modport master (
    output value, load, enable, blank_lz,
    input  seg, an, digit_idx, frame_done
  );

  modport slave (
    input  value, load, enable, blank_lz,
    output seg, an, digit_idx, frame_done
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Shared by every display block in the slice.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_seg(nib);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit hex scanner with snapshot shadow/display registers.
// The shown word only changes at frame boundaries so digits never tear.
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 500,
  parameter int CW    = 16
) (
  input  logic clk,
  input  logic rst,
  hex_display_scanner_if.slave bus
);

  logic [31:0]   shadow;
  logic [31:0]   disp;
  logic [CW-1:0] pre;
  logic [2:0]    idx;
  logic [0:0]    state;
  logic [6:0]    seg_q;
  logic [7:0]    an_q;
  logic          fd_q;

  logic [31:0] hi;
  logic [6:0]  glyph;
  logic        blank;
  logic        slot_end;
  logic        guard_end;

  // hi holds the current nibble and everything above it
  assign hi        = disp >> {idx, 2'b00};
  assign blank     = bus.blank_lz && (idx != 3'd0) && (hi == 32'd0);
  assign slot_end  = (pre == CW'(DIV - 1));
  assign guard_end = (pre == CW'(GUARD - 1));

  hex_to_seg7 u_dec (
    .nib (hi[3:0]),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      disp   <= '0;
      pre    <= '0;
      idx    <= '0;
      state  <= GUARD_S;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      fd_q   <= 1'b0;
    end else begin
      if (fd_q)
        disp <= shadow;
      if (bus.load)
        shadow <= bus.value;
      if (!bus.enable) begin
        pre   <= '0;
        idx   <= '0;
        state <= GUARD_S;
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        fd_q  <= 1'b0;
      end else begin
        pre  <= slot_end ? '0 : pre + CW'(1);
        fd_q <= slot_end && (idx == 3'd7);
        case (state)
          DRIVE_S: begin
            an_q  <= ~(8'd1 << idx);
            seg_q <= blank ? SEG_OFF : glyph;
            if (slot_end) begin
              state <= GUARD_S;
              idx   <= idx + 3'd1;
            end
          end
          default: begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            if (guard_end)
              state <= DRIVE_S;
          end
        endcase
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized self-checking bench for hex_display_scanner (DIV=4, GUARD=1).
// Reference model derives outputs from elapsed enabled cycles.
module tb_hex_display_scanner;

  localparam int DIVT   = 4;
  localparam int GUARDT = 1;
  localparam int FRAME  = 8 * DIVT;

  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_display_scanner_if bus();

  hex_display_scanner #(
    .DIV   (DIVT),
    .GUARD (GUARDT),
    .CW    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_shadow, m_disp;
  int          m_n;
  logic        m_fd;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic [2:0]  m_idx;

  task automatic tick();
    logic [31:0] nd;
    logic [31:0] up;
    int p, d;
    @(posedge clk);
    if (rst) begin
      m_shadow = '0; m_disp = '0; m_n = 0; m_fd = 0;
      m_an = 8'hFF; m_seg = 7'h7F; m_idx = 0;
    end else begin
      nd = m_fd ? m_shadow : m_disp;
      if (bus.load) m_shadow = bus.value;
      if (!bus.enable) begin
        m_n = 0; m_fd = 0; m_an = 8'hFF; m_seg = 7'h7F; m_idx = 0;
      end else begin
        p = m_n % DIVT;
        d = (m_n / DIVT) % 8;
        if (p < GUARDT) begin
          m_an = 8'hFF; m_seg = 7'h7F;
        end else begin
          up = m_disp >> (4 * d);
          m_an = ~(8'd1 << d);
          m_seg = (bus.blank_lz && d != 0 && up == 0) ? 7'h7F : TBL[up % 16];
        end
        m_n++;
        m_fd = (m_n % FRAME == 0);
        m_idx = 3'((m_n / DIVT) % 8);
      end
      m_disp = nd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.load = 0; bus.enable = 0; bus.blank_lz = 0; bus.value = '0;
    tick();
    tick();
    vecs++;
    if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset: an=%h seg=%h idx=%0d fd=%b, expected FF 7F 0 0",
               bus.an, bus.seg, bus.digit_idx, bus.frame_done);
    end
    rst = 0;
  endtask

  task automatic test_zero_scan();
    int pulses = 0;
    bus.enable = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      vecs++;
      pulses += bus.frame_done;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL zero_scan cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
    vecs++;
    if (pulses !== 2) begin
      errs++;
      $display("FAIL zero_scan_pulses: got %0d, expected 2", pulses);
    end
  endtask

  task automatic test_hex_value();
    bus.value = 32'h89ABCDEF; bus.load = 1;
    tick();
    bus.load = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL hex_value cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [31:0] vals [2] = '{32'h000000A5, 32'h0};
    bus.blank_lz = 1;
    for (int k = 0; k < 2; k++) begin
      bus.value = vals[k]; bus.load = 1;
      tick();
      bus.load = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
        tick();
        vecs++;
        if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
          errs++;
          $display("FAIL blank_lz v=%h cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", vals[k], i,
                   bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
        end
      end
    end
    bus.blank_lz = 0;
  endtask

  task automatic test_anti_tear();
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      hit = (m_idx == 3) && (m_n % DIVT == 2);
      if (!hit) begin
        tick();
        vecs++;
        if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
          errs++;
          $display("FAIL anti_tear_wait cyc %0d: got %h/%h exp %h/%h", i, bus.an, bus.seg, m_an, m_seg);
        end
      end
    end
    vecs++;
    if (!hit) begin
      errs++;
      $display("FAIL anti_tear_sync: digit 3 not reached, idx=%0d expected 3", m_idx);
    end
    bus.value = 32'h11111111; bus.load = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      bus.load = 0;
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL anti_tear cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit hit = 0;
    bus.value = 32'h1; bus.load = 1;
    tick();
    bus.load = 0;
    tick(); tick();
    bus.value = 32'h2; bus.load = 1;
    tick();
    bus.load = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL two_loads cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      tick();
      hit = bus.frame_done;
    end
    vecs++;
    if (!hit || m_fd !== 1'b1) begin
      errs++;
      $display("FAIL fd_load_sync: fd=%b, expected 1", bus.frame_done);
    end
    bus.value = $urandom; bus.load = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      bus.load = 0;
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL fd_load cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < FRAME && !(m_idx == 5 && m_n % DIVT == 2); i++)
      tick();
    bus.enable = 0;
    tick();
    vecs++;
    if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
      errs++;
      $display("FAIL disable: got %h/%h/%0d/%b expected FF/7F/0/0",
               bus.an, bus.seg, bus.digit_idx, bus.frame_done);
    end
    bus.value = $urandom; bus.load = 1;
    tick();
    bus.load = 0;
    tick();
    bus.enable = 1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL reenable cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
  endtask

  task automatic test_rst_load();
    rst = 1; bus.value = $urandom | 32'h1; bus.load = 1;
    tick();
    rst = 0; bus.load = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL rst_load cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 700 == 0);
      bus.load = ($urandom % 24 == 0);
      bus.value = ($urandom % 2) ? $urandom : ($urandom >> ($urandom % 32));
      if ($urandom % 150 == 0) bus.enable = ~bus.enable;
      if ($urandom % 200 == 0) bus.blank_lz = ~bus.blank_lz;
      tick();
      vecs++;
      if ({bus.an, bus.seg, bus.digit_idx, bus.frame_done} !== {m_an, m_seg, m_idx, m_fd}) begin
        errs++;
        $display("FAIL random cyc %0d: got %h/%h/%0d/%b exp %h/%h/%0d/%b", i,
                 bus.an, bus.seg, bus.digit_idx, bus.frame_done, m_an, m_seg, m_idx, m_fd);
      end
    end
    rst = 0; bus.load = 0;
  endtask

  initial begin
    rst = 1; bus.load = 0; bus.enable = 0; bus.blank_lz = 0; bus.value = '0;
    test_reset();
    test_zero_scan();
    test_hex_value();
    test_blank_lz();
    test_anti_tear();
    test_back_to_back();
    test_enable();
    test_rst_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream of the 32-bit adder datapath. Shows a 32-bit result as 8 hexadecimal digits on a time-multiplexed common-anode seven-segment display, one digit at a time.
- Removes the need to step through byte slices with the select switches.
- Captures a snapshot of the value. The displayed value changes only at frame boundaries, so the display never tears.
- Optionally blanks leading zeros.

Parameters:
- DIV, 50000: clock cycles per digit slot; minimum 2.
- GUARD, 500: cycles at the start of each slot with all anodes off, to avoid ghosting; must be 1..DIV-1.
- CW, 16: prescaler width; must satisfy 2^CW >= DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  32  result word to display (sum from adder)
- load  in  1  one-cycle strobe; capture value into the shadow register
- enable  in  1  1 = scan display; 0 = display dark, scanning held in reset state
- blank_lz  in  1  1 = suppress leading zero digits
- seg  out  7  segment drive, active-low; bit0=a, bit1=b, ..., bit6=g
- an  out  8  anode drive, active-low; an[i] selects digit i, where digit 0 = value[3:0]
- digit_idx  out  3  index of the slot currently being scanned
- frame_done  out  1  one-cycle pulse when digit 7 slot ends

Behaviour:
- Reset (rst=1 at a clk edge):
  - shadow=0, disp=0, prescaler=0, digit_idx=0, state=GUARD_S
  - an=8'hFF, seg=7'h7F, frame_done=0
  - rst has priority over load and enable.
- Registers:
  - shadow: 32-bit, written with value on the cycle after load=1, so latency is 1. A second load before the frame boundary overwrites it; last load wins.
  - disp: 32-bit, source for all segment decoding. disp <= shadow only on the frame_done cycle.
  - If load and the frame boundary coincide, disp takes the old shadow; the new value appears one frame later.
- Prescaler:
  - Counts 0..DIV-1 while enable=1, then wraps to 0.
  - Slot end is the cycle where prescaler==DIV-1.
- State machine, two states, evaluated each cycle while enable=1:
  - GUARD_S: an=8'hFF, seg=7'h7F. Go to DRIVE_S when prescaler==GUARD-1.
  - DRIVE_S: an = ~(1<<digit_idx), seg = decode(disp nibble digit_idx). At slot end, go to GUARD_S and increment digit_idx.
- Wrap: at the digit 7 slot end, digit_idx wraps to 0, frame_done=1 for exactly that cycle, and disp is updated.
- enable=0: registered outputs go dark on the next edge (an=8'hFF, seg=7'h7F). prescaler=0, digit_idx=0, state=GUARD_S, frame_done=0. The shadow register still accepts load.
- Re-enable: scanning restarts at digit 0, GUARD_S, prescaler 0.
- Outputs are registered: an and seg reflect the state and prescaler of the previous cycle.
- Leading-zero blanking:
  - Digit i (i>=1) is blanked when blank_lz=1 and disp[31:4*i]==0.
  - Blanked means an[i] is still asserted in its slot but seg=7'h7F.
  - Digit 0 is never blanked, so value 0 shows "0".
- Hex decode (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Full frame = 8*DIV cycles, with at most one anode low at any cycle.
- Mid-operation reset returns to the reset state on the next edge; no partial frame completes.

Decomposition:
- Shared package seg7_pkg:
  - hex-to-segment constant table
  - SEG_OFF=7'h7F, AN_OFF=8'hFF
  - state encoding GUARD_S=1'b0, DRIVE_S=1'b1
- One sub-module, hex_to_seg7 (4-bit nibble in, 7-bit active-low out), purely combinational; reused by later display blocks.
- Scanner FSM, prescaler and registers stay in hex_display_scanner.

Test Plan (bench uses DIV=4, GUARD=1):
- Reset, enable=1, no load: digits 0..7 each show seg=7'h40 in turn; an cycles FE,FD,FB,...,7F, with an=FF for 1 of every 4 cycles; frame_done pulses every 32 cycles.
- load with value=32'h89ABCDEF, wait for frame_done: in the next frame digit 0 seg=0E, digit 1 06, digit 2 21, digit 3 46, digit 4 03, digit 5 08, digit 6 10, digit 7 00.
- blank_lz=1, value=32'h000000A5: digits 0,1 show 12,08; digits 2..7 have an asserted in their slot with seg=7F. Value 0 shows only digit 0 = 40.
- Anti-tear: load 32'h11111111 mid-frame at digit 3: digits 4..7 of the current frame still show the old value; all digits show 79 starting from the next frame.
- Two loads, 32'h1 then 32'h2, within one frame: the next frame shows 2 on digit 0. A load on the frame_done cycle is delayed by exactly one frame.
- enable=0 at digit 5: an=FF and seg=7F from the next cycle. On re-enable the scan restarts with the digit 0 guard slot. rst asserted together with load leaves shadow=0.
